// File: rtl/ball_pool_pkg.sv
// Screen constants and shared widths for the projectile pool.
// Imported by the pool interface, the slot and the pool top.
package ball_pool_pkg;

    localparam int unsigned X_W           = 7;
    localparam int unsigned Y_W           = 6;
    localparam int unsigned SCREEN_W      = 96;
    localparam int unsigned DEFAULT_SLOTS = 12;
    localparam int unsigned HIT_W         = 4;

    typedef logic [X_W-1:0] x_t;

endpackage

// File: rtl/ball_pool_if.sv
// Control and display bundle between a projectile pool and its game logic.
interface ball_pool_if
    import ball_pool_pkg::*;
#(
    parameter int unsigned SLOTS = DEFAULT_SLOTS
);

    logic                   move_en;
    logic                   shoot;
    logic                   shooter_alive;
    logic                   clear;
    logic [SLOTS-1:0]       ball_en;
    logic [X_W*SLOTS-1:0]   ball_x;
    logic                   hit_pulse;
    logic [HIT_W-1:0]       hit_count;
    logic                   drop_pulse;

    modport master (
        output move_en, shoot, shooter_alive, clear,
        input  ball_en, ball_x, hit_pulse, hit_count, drop_pulse
    );

    modport slave (
        input  move_en, shoot, shooter_alive, clear,
        output ball_en, ball_x, hit_pulse, hit_count, drop_pulse
    );

endinterface

// File: rtl/ball_slot.sv
// One projectile slot: active flag, column, and the retire-at-target decision.
module ball_slot
    import ball_pool_pkg::*;
#(
    parameter x_t          START_X   = 7'd11,
    parameter x_t          TARGET_X  = 7'd74,
    parameter bit          DIR_RIGHT = 1'b1,
    parameter int unsigned STEP      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic move_en,
    input  logic load,
    output logic en,
    output x_t   x,
    output logic retire
);

    // Compare one bit wider so the sum/threshold never wraps.
    logic [X_W:0] x_ext;
    logic [X_W:0] step_ext;
    logic [X_W:0] tgt_ext;
    logic         at_target;

    assign x_ext    = {1'b0, x};
    assign step_ext = (X_W + 1)'(STEP);
    assign tgt_ext  = {1'b0, TARGET_X};

    always_comb begin
        at_target = 1'b0;
        if (DIR_RIGHT) at_target = (x_ext + step_ext) >= tgt_ext;
        else           at_target = x_ext <= (tgt_ext + step_ext);
    end

    assign retire = en && move_en && at_target && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            en <= 1'b0;
            x  <= '0;
        end else if (clear) begin
            en <= 1'b0;
        end else if (en && move_en) begin
            if (at_target)      en <= 1'b0;
            else if (DIR_RIGHT) x  <= x + X_W'(STEP);
            else                x  <= x - X_W'(STEP);
        end else if (load) begin
            en <= 1'b1;
            x  <= START_X;
        end
    end

endmodule

// File: rtl/ball_pool.sv
// Fixed pool of projectile slots: edge-detected launch with cooldown,
// lowest-free-slot allocation, per-tick movement and registered hit/drop pulses.
module ball_pool
    import ball_pool_pkg::*;
#(
    parameter int unsigned SLOTS     = DEFAULT_SLOTS,
    parameter x_t          START_X   = 7'd11,
    parameter x_t          TARGET_X  = 7'd74,
    parameter bit          DIR_RIGHT = 1'b1,
    parameter int unsigned STEP      = 1,
    parameter int unsigned COOLDOWN  = 8
) (
    input  logic       clk_50Hz,
    input  logic       reset,
    ball_pool_if.slave bus
);

    localparam int unsigned CD_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;

    logic                 shoot_q;
    logic [CD_W-1:0]      cooldown;
    logic                 shoot_edge;
    logic                 accept;
    logic                 free_found;
    logic [SLOTS-1:0]     free_onehot;
    logic [SLOTS-1:0]     slot_en;
    logic [SLOTS-1:0]     slot_retire;
    logic [SLOTS-1:0]     slot_load;
    logic [X_W*SLOTS-1:0] slot_x;
    logic [HIT_W-1:0]     hits;
    logic [HIT_W-1:0]     hit_count_q;
    logic                 hit_pulse_q;
    logic                 drop_pulse_q;

    assign shoot_edge = bus.shoot && !shoot_q;
    assign accept     = shoot_edge && (cooldown == '0) && bus.shooter_alive && !bus.clear;

    // A slot retiring this cycle still reads en = 1 here, so it cannot be reused yet.
    always_comb begin
        free_onehot = '0;
        free_found  = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!slot_en[i] && !free_found) begin
                free_onehot[i] = 1'b1;
                free_found     = 1'b1;
            end
        end
    end

    always_comb begin
        hits = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            hits = hits + HIT_W'(slot_retire[i]);
        end
    end

    assign slot_load = (accept && free_found) ? free_onehot : '0;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        ball_slot #(
            .START_X   (START_X),
            .TARGET_X  (TARGET_X),
            .DIR_RIGHT (DIR_RIGHT),
            .STEP      (STEP)
        ) u_slot (
            .clk     (clk_50Hz),
            .reset   (reset),
            .clear   (bus.clear),
            .move_en (bus.move_en),
            .load    (slot_load[g]),
            .en      (slot_en[g]),
            .x       (slot_x[X_W*g +: X_W]),
            .retire  (slot_retire[g])
        );
    end

    always_ff @(posedge clk_50Hz) begin
        if (reset) begin
            shoot_q      <= 1'b0;
            cooldown     <= '0;
            hit_count_q  <= '0;
            hit_pulse_q  <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else if (bus.clear) begin
            shoot_q      <= 1'b0;
            cooldown     <= '0;
            hit_count_q  <= '0;
            hit_pulse_q  <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            shoot_q      <= bus.shoot;
            hit_count_q  <= hits;
            hit_pulse_q  <= (hits != '0);
            drop_pulse_q <= accept && !free_found;
            // A dropped request leaves the cooldown idle so the player can retry at once.
            if (accept && free_found) cooldown <= CD_W'(COOLDOWN - 1);
            else if (cooldown != '0)  cooldown <= cooldown - 1'b1;
        end
    end

    assign bus.ball_en    = slot_en;
    assign bus.ball_x     = slot_x;
    assign bus.hit_count  = hit_count_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.drop_pulse = drop_pulse_q;

endmodule

// File: doc/ball_pool.md
BALL_POOL -- requirements
Module: ball_pool

Interface
REQ-001 Parameter SLOTS, default 12: number of projectile slots.
REQ-002 Parameter START_X, default 7'd11: column a ball takes at launch.
REQ-003 Parameter TARGET_X, default 7'd74: column at which a ball retires as a hit.
REQ-004 Parameter DIR_RIGHT, default 1: 1 moves balls toward larger X, 0 toward smaller X.
REQ-005 Parameter STEP, default 1: columns moved per move tick, range 1..7.
REQ-006 Parameter COOLDOWN, default 8: minimum cycles between accepted launches.
REQ-007 Port clk_50Hz, input, 1: sole clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1: synchronous, active-high reset.
REQ-009 Port move_en, input, 1: move tick qualifier, high for one cycle per step.
REQ-010 Port shoot, input, 1: level shoot request from the debounced player button.
REQ-011 Port shooter_alive, input, 1: launches are allowed only while high.
REQ-012 Port clear, input, 1: synchronous pool flush at round end.
REQ-013 Port ball_en, output, SLOTS: per-slot active flag, bit i = slot i.
REQ-014 Port ball_x, output, 7*SLOTS: packed left-X per slot; slot i occupies bits [7i+6:7i].
REQ-015 Port hit_pulse, output, 1: high for one cycle when one or more balls retire at TARGET_X.
REQ-016 Port hit_count, output, 4: number of balls retired as hits in the same cycle.
REQ-017 Port drop_pulse, output, 1: high for one cycle when an accepted edge finds no free slot.

Function
REQ-018 Shoot SHALL be edge-detected internally; only a 0->1 transition of shoot counts as a request, and holding shoot high SHALL launch at most once.
REQ-019 A request SHALL be accepted when cooldown counter = 0, shooter_alive = 1 and clear = 0.
REQ-020 On acceptance with a free slot, the lowest-index slot with ball_en = 0 SHALL be loaded: en = 1 and x = START_X, both visible the next cycle.
REQ-021 On acceptance the cooldown counter SHALL load COOLDOWN-1 and decrement once per cycle to 0. With COOLDOWN = 8, the next edge is accepted no earlier than 8 cycles later.
REQ-022 On acceptance with all slots busy, the pool SHALL leave the slots unchanged, pulse drop_pulse, and not load cooldown.
REQ-023 On a cycle with move_en = 1, every slot active at the start of the cycle SHALL advance by STEP toward TARGET_X. A slot launched in that same cycle SHALL NOT move.
REQ-024 Retire rule, DIR_RIGHT = 1: if x + STEP >= TARGET_X (computed 8-bit, no wrap), the slot clears en instead of moving.
REQ-025 Retire rule, DIR_RIGHT = 0: if x <= TARGET_X + STEP (computed 8-bit, no underflow), the slot clears en instead of moving.
REQ-026 A retired slot's x SHALL hold its last value; display consumers gate on ball_en.
REQ-027 A retiring slot SHALL NOT be reused for a launch in the same cycle; it is free from the next cycle.
REQ-028 hit_count SHALL equal the popcount of the slots retiring this cycle; hit_pulse = (hit_count != 0). Both are registered, one cycle after the retire edge.
REQ-029 clear = 1 SHALL zero ball_en, the cooldown counter, and the shoot edge history. It SHALL suppress launches and hits that cycle, and SHALL NOT assert hit_pulse or drop_pulse.
REQ-030 Priority SHALL be reset > clear > retire/move > launch.
REQ-031 shooter_alive = 0 SHALL block new launches only; balls already in flight continue to move and retire.

Reset
REQ-032 On reset, all outputs and state SHALL go to zero: ball_en = 0, ball_x = 0, hit_pulse = 0, hit_count = 0, drop_pulse = 0, cooldown = 0, shoot edge history = 0.
REQ-033 A reset asserted mid-flight SHALL discard all balls with no hit reported.

Structure
REQ-034 A shared package SHALL hold the screen constants: X width 7, Y width 6, screen width 96, and the default SLOTS.
REQ-035 One sub-module, ball_slot, SHALL hold a single slot's en, x and retire logic. ball_pool SHALL instantiate it SLOTS times, plus a priority encoder and a popcount.
REQ-036 Two instances (DIR_RIGHT = 1, START_X = 11, TARGET_X = 74 and DIR_RIGHT = 0, START_X = 73, TARGET_X = 12) SHALL drive the fireball and waterball display inputs unchanged.

Verification
REQ-037 Scenario: reset, then one shoot edge with move_en held 1 -> ball_en = 12'h001 and x = 11, then 12, 13, ...; at x = 73, hit_pulse = 1 with hit_count = 1 on the following cycle and ball_en = 0.
REQ-038 Scenario: shoot held high for 20 cycles -> exactly one launch.
REQ-039 Scenario: edges every 8 cycles (12 times), then a 13th edge before any retire -> ball_en = 12'hFFF, drop_pulse once, slots unchanged.
REQ-040 Scenario: edges 3 cycles apart -> second edge ignored (cooldown); an edge at +8 is accepted into slot 1.
REQ-041 Scenario: two balls forced adjacent with STEP = 2 reaching the target on the same tick -> hit_count = 2, single hit_pulse.
REQ-042 Scenario: clear asserted while 5 balls fly and one is retiring -> ball_en = 0 next cycle, no hit_pulse; DIR_RIGHT = 0 instance with x = 13 and STEP = 1 retires without underflow.
